// File: rtl/signed_sub_with_saturation_pipe_pkg.sv
// Shared types for the saturating subtractor pipeline and its clamp.
// No logic, no latency, no backpressure.
package signed_sub_with_saturation_pipe_pkg;

    typedef struct packed {
        logic pos;
        logic neg;
    } sat_flags_t;

    localparam int SAT_FLAGS_W = $bits(sat_flags_t);

endpackage

// File: rtl/signed_sub_with_saturation_pipe_if.sv
// Stream bundle for the subtractor: operand side in, result side out.
// slave is the datapath view, master is the producer/consumer view.
interface signed_sub_with_saturation_pipe_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             sat_pos;
    logic             sat_neg;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, sat_pos, sat_neg
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, sat_pos, sat_neg
    );
endinterface

// File: rtl/pipe_stage.sv
// Generic one-entry valid/ready register slice; 1 cycle latency.
// Backpressure: accepts when empty or when the downstream takes the held entry.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    assign in_rdy = ~out_vld | out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
            end
        end
    end
endmodule

// File: rtl/sat_clamp.sv
// Clamps a (WIDTH+1)-bit signed value to WIDTH bits and flags the direction.
// Combinational, no latency, no backpressure.
module sat_clamp
    import signed_sub_with_saturation_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   raw,
    output logic [WIDTH-1:0] clamped,
    output sat_flags_t       flags
);
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // The two top bits disagree exactly when the value does not fit in WIDTH bits.
    always_comb begin
        flags.pos = (raw[WIDTH -: 2] == 2'b01);
        flags.neg = (raw[WIDTH -: 2] == 2'b10);
        clamped   = raw[WIDTH-1:0];
        if (flags.pos) begin
            clamped = MAX;
        end else if (flags.neg) begin
            clamped = MIN;
        end
    end
endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// Streaming saturating a - b with a saturation event counter; 2 cycle latency.
// Backpressure: combinational ready chain, both stages hold while the output is stalled.
module signed_sub_with_saturation_pipe
    import signed_sub_with_saturation_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    signed_sub_with_saturation_pipe_if.slave     bus,
    input  logic                                 sat_cnt_clr,
    output logic [CNT_W-1:0]                     sat_cnt
);
    localparam int S2_W = WIDTH + SAT_FLAGS_W;

    logic [WIDTH:0]   raw_diff;
    logic [WIDTH:0]   s1_dat;
    logic             s1_vld;
    logic             s1_rdy;
    logic [WIDTH-1:0] clamp_val;
    sat_flags_t       clamp_flags;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_dat;
    logic             s2_vld;
    logic             s2_rdy;
    sat_flags_t       out_flags;
    logic             sat_xfer;

    // One extra bit keeps the raw difference exact, including b = MIN.
    assign raw_diff = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};

    pipe_stage #(.W(WIDTH + 1)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (bus.in_valid),
        .in_dat  (raw_diff),
        .in_rdy  (s1_rdy),
        .out_vld (s1_vld),
        .out_dat (s1_dat),
        .out_rdy (s2_rdy)
    );

    sat_clamp #(.WIDTH(WIDTH)) u_clamp (
        .raw     (s1_dat),
        .clamped (clamp_val),
        .flags   (clamp_flags)
    );

    assign s2_in = {clamp_flags, clamp_val};

    pipe_stage #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (s1_vld),
        .in_dat  (s2_in),
        .in_rdy  (s2_rdy),
        .out_vld (s2_vld),
        .out_dat (s2_dat),
        .out_rdy (bus.out_ready)
    );

    assign out_flags     = sat_flags_t'(s2_dat[S2_W-1:WIDTH]);
    assign bus.in_ready  = s1_rdy;
    assign bus.out_valid = s2_vld;
    assign bus.diff      = s2_dat[WIDTH-1:0];
    assign bus.sat_pos   = out_flags.pos;
    assign bus.sat_neg   = out_flags.neg;

    assign sat_xfer = s2_vld & bus.out_ready & (out_flags.pos | out_flags.neg);

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || sat_cnt_clr) begin
            sat_cnt <= '0;
        end else if (sat_xfer && (sat_cnt != {CNT_W{1'b1}})) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Bench for the saturating subtractor: directed cases, exhaustive sweep, random stalls.
module tb_signed_sub_with_saturation_pipe;
    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sat_cnt_clr = 1'b0;
    logic [CW-1:0] sat_cnt;

    signed_sub_with_saturation_pipe_if #(.WIDTH(W)) bus ();

    signed_sub_with_saturation_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [5:0] exp_q[$];   // {sat_pos, sat_neg, diff} in acceptance order
    int         cnt_m  = 0;

    // Reference: exact integer difference, then clamp to the 4-bit range.
    function automatic logic [5:0] ref_sub(input logic [3:0] a, input logic [3:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        if (d > 7)  return {2'b10, 4'h7};
        if (d < -8) return {2'b01, 4'h8};
        return {2'b00, 4'(d)};
    endfunction

    // Drives one cycle (changes at negedge), reports what the coming posedge transfers.
    task automatic drive(input logic iv, input logic [3:0] ia, input logic [3:0] ib,
                         input logic ordy, input logic clr,
                         output logic took, output logic ov,
                         output logic [5:0] res, output logic [5:0] exp);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.out_ready = ordy;
        sat_cnt_clr   = clr;
        #1;
        took = iv && bus.in_ready;
        ov   = bus.out_valid;
        res  = {bus.sat_pos, bus.sat_neg, bus.diff};
        exp  = 'x;
        if (ov && ordy && exp_q.size() > 0) exp = exp_q.pop_front();
        if (took) exp_q.push_back(ref_sub(ia, ib));
        if (clr) cnt_m = 0;
        else if (ov && ordy && ((exp[5] | exp[4]) === 1'b1) && cnt_m < 255) cnt_m++;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.out_ready = 1'b0; sat_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.diff !== 4'h0) begin n_fail++; $display("FAIL reset_diff got %h want 0", bus.diff); end
        n_cmp++; if (bus.sat_pos !== 1'b0) begin n_fail++; $display("FAIL reset_sat_pos got %b want 0", bus.sat_pos); end
        n_cmp++; if (bus.sat_neg !== 1'b0) begin n_fail++; $display("FAIL reset_sat_neg got %b want 0", bus.sat_neg); end
        n_cmp++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_sat_cnt got %0d want 0", sat_cnt); end
        @(negedge clk);
        rst = 1'b0; exp_q.delete(); cnt_m = 0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_latency();
        logic took, ov; logic [5:0] res, exp;
        drive(1'b1, 4'h7, 4'hF, 1'b1, 1'b0, took, ov, res, exp);
        n_cmp++; if (took !== 1'b1) begin n_fail++; $display("FAIL lat_accept got %b want 1", took); end
        drive(1'b1, 4'h3, 4'h5, 1'b1, 1'b0, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL lat_early got out_valid %b want 0", ov); end
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b1 || res !== {2'b10, 4'h7}) begin n_fail++; $display("FAIL lat_first got vld %b res %h want vld 1 res %h", ov, res, {2'b10, 4'h7}); end
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b1 || res !== {2'b00, 4'hE}) begin n_fail++; $display("FAIL lat_second got vld %b res %h want vld 1 res %h", ov, res, {2'b00, 4'hE}); end
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL lat_drain got out_valid %b want 0", ov); end
    endtask

    task automatic test_edges();
        logic took, ov; logic [5:0] res, exp;
        logic [3:0] ta[4] = '{4'h8, 4'h8, 4'h0, 4'hF};
        logic [3:0] tb_b[4] = '{4'h1, 4'h8, 4'h8, 4'h8};
        logic [5:0] tr[4] = '{{2'b01, 4'h8}, {2'b00, 4'h0}, {2'b10, 4'h7}, {2'b00, 4'h7}};
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            drive(i < 4, (i < 4) ? ta[i] : 4'h0, (i < 4) ? tb_b[i] : 4'h0, 1'b1, 1'b0, took, ov, res, exp);
            if (ov) begin
                n_cmp++;
                if (k >= 4) begin n_fail++; $display("FAIL edge_extra got result %h want none", res); end
                else if (res !== tr[k]) begin n_fail++; $display("FAIL edge_%0d got %h want %h", k, res, tr[k]); end
                k++;
            end
        end
        n_cmp++; if (k != 4) begin n_fail++; $display("FAIL edge_count got %0d want 4", k); end
    endtask

    task automatic test_exhaustive();
        logic took, ov; logic [5:0] res, exp; logic [7:0] p;
        int n_out = 0, n_sat = 0;
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, took, ov, res, exp);
        for (int i = 0; i < 260; i++) begin
            p = 8'(i);
            drive(i < 256, p[7:4], p[3:0], 1'b1, 1'b0, took, ov, res, exp);
            if (i < 256) begin
                n_cmp++; if (took !== 1'b1) begin n_fail++; $display("FAIL exh_in_ready cycle %0d got %b want 1", i, took); end
            end
            if (i >= 2 && i < 258) begin
                n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL exh_gap cycle %0d got out_valid %b want 1", i, ov); end
            end
            if (ov) begin
                n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL exh_diff cycle %0d got %h want %h", i, res, exp); end
                n_out++;
                if ((exp[5] | exp[4]) === 1'b1) n_sat++;
            end
        end
        @(posedge clk);
        #1;
        n_cmp++; if (n_out != 256) begin n_fail++; $display("FAIL exh_count got %0d want 256", n_out); end
        n_cmp++; if (sat_cnt !== 8'(n_sat)) begin n_fail++; $display("FAIL exh_sat_cnt got %0d want %0d", sat_cnt, n_sat); end
    endtask

    task automatic test_backpressure();
        logic took, ov; logic [5:0] res, exp, held;
        logic [3:0] pa, pb;
        int n_took = 0, n_out = 0;
        pa = 4'($urandom); pb = 4'($urandom); held = '0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pa, pb, 1'b0, 1'b0, took, ov, res, exp);
            if (took) begin n_took++; pa = 4'($urandom); pb = 4'($urandom); end
            if (i == 2) held = res;
            if (i >= 2) begin
                n_cmp++; if (took !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, took); end
            end
            if (i > 2) begin
                n_cmp++; if (res !== held) begin n_fail++; $display("FAIL bp_stable cycle %0d got %h want %h", i, res, held); end
            end
        end
        n_cmp++; if (n_took != 2) begin n_fail++; $display("FAIL bp_buffered got %0d want 2", n_took); end
        for (int i = 0; i < 12; i++) begin
            drive(i < 6, pa, pb, 1'b1, 1'b0, took, ov, res, exp);
            if (took) begin n_took++; pa = 4'($urandom); pb = 4'($urandom); end
            if (ov) begin
                n_out++;
                n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL bp_release got %h want %h", res, exp); end
            end
        end
        n_cmp++; if (n_out != n_took) begin n_fail++; $display("FAIL bp_no_loss got %0d outputs want %0d", n_out, n_took); end
    endtask

    task automatic test_random();
        logic took, ov, iv, ordy; logic [5:0] res, exp;
        logic [3:0] pa, pb;
        pa = 4'($urandom); pb = 4'($urandom);
        for (int i = 0; i < 404; i++) begin
            iv   = (i < 400) && ($urandom_range(0, 3) != 0);
            ordy = (i >= 400) || ($urandom_range(0, 3) != 0);
            drive(iv, pa, pb, ordy, 1'b0, took, ov, res, exp);
            if (took) begin pa = 4'($urandom); pb = 4'($urandom); end
            if (ov && ordy) begin
                n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL rand_diff cycle %0d got %h want %h", i, res, exp); end
            end
        end
        @(posedge clk);
        #1;
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (sat_cnt !== 8'(cnt_m)) begin n_fail++; $display("FAIL rand_sat_cnt got %0d want %0d", sat_cnt, cnt_m); end
    endtask

    task automatic test_sat_cnt();
        logic took, ov; logic [5:0] res, exp;
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, took, ov, res, exp);
        for (int i = 0; i < 302; i++)
            drive(i < 300, 4'h7, 4'(8 + $urandom_range(0, 7)), 1'b1, 1'b0, took, ov, res, exp);
        @(posedge clk);
        #1;
        n_cmp++; if (sat_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_top got %0d want 255", sat_cnt); end
        for (int i = 0; i < 7; i++)
            drive(i < 5, 4'h8, 4'(1 + $urandom_range(0, 6)), 1'b1, 1'b0, took, ov, res, exp);
        @(posedge clk);
        #1;
        n_cmp++; if (sat_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_stick got %0d want 255", sat_cnt); end
        drive(1'b1, 4'h7, 4'h8, 1'b1, 1'b0, took, ov, res, exp);
        drive(1'b1, 4'h7, 4'h8, 1'b1, 1'b0, took, ov, res, exp);
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b1 || res !== {2'b10, 4'h7}) begin n_fail++; $display("FAIL cnt_clr_xfer got vld %b res %h want vld 1 res %h", ov, res, {2'b10, 4'h7}); end
        @(posedge clk);
        #1;
        n_cmp++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_clr got %0d want 0", sat_cnt); end
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
        @(posedge clk);
        #1;
        n_cmp++; if (sat_cnt !== 8'd1) begin n_fail++; $display("FAIL cnt_after_clr got %0d want 1", sat_cnt); end
    endtask

    task automatic test_reset_midflight();
        logic took, ov; logic [5:0] res, exp;
        drive(1'b1, 4'h7, 4'h8, 1'b0, 1'b0, took, ov, res, exp);
        drive(1'b1, 4'h8, 4'h1, 1'b0, 1'b0, took, ov, res, exp);
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got vld %b in_ready %b want 1 0", ov, bus.in_ready); end
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (sat_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_sat_cnt got %0d want 0", sat_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0; exp_q.delete(); cnt_m = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
            n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL mid_stale cycle %0d got out_valid %b want 0", i, ov); end
        end
        drive(1'b1, 4'h3, 4'h5, 1'b1, 1'b0, took, ov, res, exp);
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, took, ov, res, exp);
        n_cmp++; if (ov !== 1'b1 || res !== {2'b00, 4'hE}) begin n_fail++; $display("FAIL mid_resume got vld %b res %h want vld 1 res %h", ov, res, {2'b00, 4'hE}); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_edges();
        test_exhaustive();
        test_backpressure();
        test_random();
        test_sat_cnt();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
